// File: rtl/cordic_vector_pkg.sv
// cordic_vector_pkg: shared CORDIC constants (atan table, gain, widths, FSM codes)
package cordic_vector_pkg;
  localparam int N_ITER = 16;
  localparam int W_INT = 20;
  localparam int W_PHASE = 16;
  localparam logic [15:0] GAIN = 16'd19899;
  localparam logic [16*16-1:0] ATAN_TBL = {
    16'd0, 16'd1, 16'd1, 16'd3, 16'd5, 16'd10, 16'd20, 16'd41,
    16'd81, 16'd163, 16'd326, 16'd651, 16'd1297, 16'd2555, 16'd4836, 16'd8192
  };
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  function automatic logic [15:0] atan_of(input int i);
    return ATAN_TBL[16*i +: 16];
  endfunction
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring iteration driving y toward zero
//   x, y, z : current state; sh : iteration index (shift); atan : angle step
//   xn, yn, zn : next state
module cordic_vec_stage #(
  parameter int IW = 20
) (
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  input  logic        [15:0]   z,
  input  logic        [3:0]    sh,
  input  logic        [15:0]   atan,
  output logic signed [IW-1:0] xn,
  output logic signed [IW-1:0] yn,
  output logic        [15:0]   zn
);
  logic signed [IW-1:0] xs, ys;
  logic up;
  assign up = ~y[IW-1];
  assign xs = x >>> sh;
  assign ys = y >>> sh;
  assign xn = up ? x + ys : x - ys;
  assign yn = up ? y - xs : y + xs;
  assign zn = up ? z + atan : z - atan;
endmodule

// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring CORDIC returning 8-bit phase and magnitude of (x_in, y_in)
//   in_valid/in_ready : sample handshake, x_in/y_in signed Q1.15
//   out_valid/out_ready : result handshake, phi (0-255 = 0-2pi), mag (unsigned, input scale)
module cordic_vector
  import cordic_vector_pkg::*;
#(
  parameter int ITER = N_ITER,
  parameter int IW = W_INT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  phi,
  output logic [15:0] mag
);
  localparam int CW = $clog2(ITER);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic signed [IW-1:0] x, y, xn, yn, xe, ye;
  logic [W_PHASE-1:0] z, zn;
  logic zero, neg;
  logic [IW+15:0] ms;
  logic [15:0] msat;
  logic [7:0] pr;
  assign in_ready = state == S_IDLE;
  assign neg = x_in[15];
  assign xe = {{(IW-18){x_in[15]}}, x_in, 2'b00};
  assign ye = {{(IW-18){y_in[15]}}, y_in, 2'b00};
  cordic_vec_stage #(.IW(IW)) u_stage (
    .x(x), .y(y), .z(z), .sh(4'(cnt)), .atan(atan_of(int'(cnt))),
    .xn(xn), .yn(yn), .zn(zn)
  );
  // x stays non-negative after folding; guard anyway, then drop the 2 guard bits with the gain shift
  assign ms = ((IW+16)'(x[IW-1] ? {IW{1'b0}} : x) * (IW+16)'(GAIN)) >> 17;
  assign msat = |ms[IW+15:16] ? 16'hFFFF : ms[15:0];
  // +half LSB before truncation so 255.5 wraps to 0
  assign pr = 8'((z + 16'd128) >> 8);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
      zero <= 1'b0;
      out_valid <= 1'b0;
      phi <= '0;
      mag <= '0;
    end else if (state == S_IDLE) begin
      if (in_valid) begin
        x <= neg ? -xe : xe;
        y <= neg ? -ye : ye;
        z <= neg ? 16'h8000 : 16'h0000;
        zero <= x_in == 16'd0 && y_in == 16'd0;
        cnt <= '0;
        state <= S_ITER;
      end
    end else if (state == S_ITER) begin
      x <= xn;
      y <= yn;
      z <= zn;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(ITER-1)) state <= S_SCALE;
    end else if (state == S_SCALE) begin
      phi <= zero ? 8'd0 : pr;
      mag <= zero ? 16'd0 : msat;
      out_valid <= 1'b1;
      state <= S_DONE;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      state <= S_IDLE;
    end
  end
endmodule
